rr_arbiter4: RTL and testbench

//  - Round-robin arbiter sharing one resource (bus/port) among 4 requesters.
//  - Grant held as 2-bit index, expanded to one-hot by an instantiated 2->4 decoder.
//  - Optional hold timeout revokes a hogging requester; a 1-cycle dead gap between owners.
//  - Sits between requester blocks and the shared datapath mux select.

---
 rtl/rr_arbiter4_pkg.sv | 14 +
 rtl/rr_arbiter4_decode24.sv | 16 +
 rtl/rr_arbiter4.sv | 116 +++++++++++
 tb/tb_rr_arbiter4.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter4_pkg.sv
// rtl/rr_arbiter4_pkg.sv - shared state encoding and sizing for the 4-way round-robin arbiter
// Ports: none (package).
package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter4_decode24.sv
// rtl/rr_arbiter4_decode24.sv - 2-to-4 one-hot decoder for the grant index
// Ports:
//   i_idx    in  2  binary index
//   o_onehot out 4  one-hot of i_idx
module rr_arbiter4_decode24
  import rr_arbiter4_pkg::*;
(
  input  logic [IDX_W-1:0]   i_idx,
  output logic [NUM_REQ-1:0] o_onehot
);

  always_comb begin
    o_onehot = NUM_REQ'(1) << i_idx;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - round-robin arbiter for 4 requesters with hold timeout and dead gap
// Ports:
//   CLK       in   1  clock, rising edge
//   Reset_L   in   1  asynchronous active-low reset
//   en        in   1  allows new grants (existing grant unaffected)
//   req       in   4  level requests, held for the whole ownership
//   gnt       out  4  one-hot grant, 0 when no owner
//   gnt_idx   out  2  index of current/last owner
//   gnt_valid out  1  grant active
//   timeout   out  1  one-cycle pulse after a timeout revoke
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic               CLK,
  input  logic               Reset_L,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  // Count value seen on the edge that ends the HOLD_MAX-th owned cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

  arb_state_e       r_state, w_state_n;
  logic [IDX_W-1:0] r_ptr, w_ptr_n;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_n;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_n;
  logic             r_timeout, w_timeout_n;

  logic [NUM_REQ-1:0] w_onehot;
  logic               w_release;
  logic               w_others;

  // First requester in circular order starting at the pointer.
  function automatic logic [IDX_W-1:0] f_pick(input logic [IDX_W-1:0] ptr,
                                              input logic [NUM_REQ-1:0] rq);
    logic [IDX_W-1:0] idx;
    f_pick = ptr;
    // Walk backwards so the closest requester to ptr is the last one written.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (rq[idx]) f_pick = idx;
    end
  endfunction

  rr_arbiter4_decode24 u_decode (
    .i_idx    (r_gnt_idx),
    .o_onehot (w_onehot)
  );

  assign w_release = ~req[r_gnt_idx];
  assign w_others  = |(req & ~w_onehot);

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_gnt_idx  <= '0;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_ptr      <= w_ptr_n;
      r_gnt_idx  <= w_gnt_idx_n;
      r_hold_cnt <= w_hold_cnt_n;
      r_timeout  <= w_timeout_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_ptr_n      = r_ptr;
    w_gnt_idx_n  = r_gnt_idx;
    w_hold_cnt_n = r_hold_cnt;
    w_timeout_n  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (en && |req) begin
          w_gnt_idx_n  = f_pick(r_ptr, req);
          w_hold_cnt_n = '0;
          w_state_n    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (r_hold_cnt != '1) w_hold_cnt_n = r_hold_cnt + 1'b1;
        // Release is checked first so it beats a coincident timeout.
        if (w_release) begin
          w_ptr_n   = r_gnt_idx + 1'b1;
          w_state_n = ST_GAP;
        end else if ((HOLD_MAX != 0) && (r_hold_cnt == HOLD_LAST) && w_others) begin
          w_ptr_n     = r_gnt_idx + 1'b1;
          w_timeout_n = 1'b1;
          w_state_n   = ST_GAP;
        end
      end
      ST_GAP: begin
        w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  assign gnt_valid = (r_state == ST_GRANT);
  assign gnt       = w_onehot & {NUM_REQ{gnt_valid}};
  assign gnt_idx   = r_gnt_idx;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - self-checking bench for rr_arbiter4 with a behavioural model
module tb_rr_arbiter4;

  localparam int HOLD = 4;

  logic       CLK;
  logic       Reset_L;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter4 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural model: who owns the resource, how many cycles it has owned it,
  // whether we sit in the dead cycle, and where the rotation starts next.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_last  = 0;
  bit m_gap   = 1'b0;
  bit m_to    = 1'b0;

  always @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_last  = 0;
      m_gap   = 1'b0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        m_held++;
        if (!req[m_owner]) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
          m_gap   = 1'b1;
        end else if (HOLD > 0 && m_held == HOLD && (req & ~(4'b0001 << m_owner)) != 4'b0000) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
          m_gap   = 1'b1;
          m_to    = 1'b1;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (en && req != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        end
        m_last = m_owner;
        m_held = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    logic [3:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check("model_gnt", 32'(gnt), 32'(exp_gnt));
    check("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("model_gnt_idx", 32'(gnt_idx), 32'(m_last));
    check("model_timeout", 32'(timeout), 32'(m_to));
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  logic [3:0] rot_exp [5];

  initial begin
    Reset_L = 1'b0;
    en      = 1'b0;
    req     = 4'b0000;
    step(3);
    Reset_L = 1'b1;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_gnt_idx", 32'(gnt_idx), 32'h0);
    check("reset_valid", 32'(gnt_valid), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);

    // Reset during a live grant, then first grant after reset goes to 0.
    en  = 1'b1;
    req = 4'b1111;
    step(1);
    check("first_grant", 32'(gnt), 32'h1);
    step(1);
    Reset_L = 1'b0;
    #1;
    check("async_reset_gnt", 32'(gnt), 32'h0);
    check("async_reset_valid", 32'(gnt_valid), 32'h0);
    Reset_L = 1'b1;
    step(1);
    check("post_reset_grant", 32'(gnt), 32'h1);

    // Rotation with all four requesting, one dead cycle between owners.
    rot_exp[0] = 4'b0001;
    rot_exp[1] = 4'b0010;
    rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000;
    rot_exp[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      check("rotation", 32'(gnt), 32'(rot_exp[k]));
      if (k < 4) begin
        step(2);
        req = req & ~rot_exp[k];
        step(1);
        check("rotation_gap", 32'(gnt), 32'h0);
        req = 4'b1111;
        step(2);
      end
    end

    // Pointer skip: release 0 so ptr=1, then 3 beats 0.
    req = 4'b1000;
    step(1);
    req = 4'b1001;
    step(2);
    check("ptr_skip", 32'(gnt), 32'h8);
    check("ptr_skip_idx", 32'(gnt_idx), 32'h3);
    req = 4'b0001;
    step(1);
    step(2);
    check("ptr_wrap", 32'(gnt), 32'h1);
    req = 4'b0000;
    step(3);

    // Timeout: 0 hogs while 2 waits.
    req = 4'b0001;
    step(1);
    check("to_hold0", 32'(gnt), 32'h1);
    req = 4'b0101;
    for (int i = 1; i < 4; i++) begin
      step(1);
      check("to_hold", 32'(gnt), 32'h1);
    end
    step(1);
    check("to_revoked", 32'(gnt), 32'h0);
    check("to_pulse", 32'(timeout), 32'h1);
    step(1);
    check("to_idle", 32'(gnt), 32'h0);
    check("to_pulse_end", 32'(timeout), 32'h0);
    step(1);
    check("to_next_owner", 32'(gnt), 32'h4);
    req = 4'b0000;
    step(3);

    // No contention: no revoke however long.
    req = 4'b0010;
    step(1);
    for (int i = 0; i < 50; i++) begin
      check("solo_gnt", 32'(gnt), 32'h2);
      check("solo_timeout", 32'(timeout), 32'h0);
      step(1);
    end
    req = 4'b0000;
    step(3);

    // en gating.
    en  = 1'b0;
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("en_off", 32'(gnt), 32'h0);
    end
    en = 1'b1;
    step(1);
    check("en_on", 32'(gnt), 32'h4);
    en = 1'b0;
    step(5);
    check("en_off_kept", 32'(gnt), 32'h4);
    req = 4'b0000;
    step(1);
    check("en_off_release", 32'(gnt), 32'h0);
    en = 1'b1;
    step(2);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        Reset_L = 1'b0;
        #1;
        Reset_L = 1'b1;
      end
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
